// File: rtl/prism_sp_tx_frame_arbiter_if.sv
// prism_sp_tx_frame_arbiter_if
// Purpose: bundles the per-core TX FIFO read sides, the shared GEM TX beat
//          stream and the arbiter status flags into one connection.
// Signals:
//   meta_empty/meta_len/meta_rd_en  per-core meta FIFO (FWFT) read side
//   data_empty/data_dout/data_rd_en per-core data FIFO (FWFT) read side
//   tx_valid/tx_ready/tx_data/tx_last/tx_bytes  outgoing beat stream
//   tx_core/busy/len_err            arbiter status
// Modports: master = arbiter side, slave = FIFO/datapath side.
interface prism_sp_tx_frame_arbiter_if #(
  parameter int unsigned NTXCORES   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 14
);
  localparam int unsigned BW = $clog2(DATA_WIDTH / 8) + 1;
  localparam int unsigned CW = (NTXCORES > 1) ? $clog2(NTXCORES) : 1;

  logic [NTXCORES-1:0]            meta_empty;
  logic [NTXCORES*LEN_WIDTH-1:0]  meta_len;
  logic [NTXCORES-1:0]            meta_rd_en;
  logic [NTXCORES-1:0]            data_empty;
  logic [NTXCORES*DATA_WIDTH-1:0] data_dout;
  logic [NTXCORES-1:0]            data_rd_en;
  logic                           tx_valid;
  logic                           tx_ready;
  logic [DATA_WIDTH-1:0]          tx_data;
  logic                           tx_last;
  logic [BW-1:0]                  tx_bytes;
  logic [CW-1:0]                  tx_core;
  logic                           busy;
  logic                           len_err;

  modport master (
    input  meta_empty, meta_len, data_empty, data_dout, tx_ready,
    output meta_rd_en, data_rd_en, tx_valid, tx_data, tx_last, tx_bytes,
           tx_core, busy, len_err
  );

  modport slave (
    output meta_empty, meta_len, data_empty, data_dout, tx_ready,
    input  meta_rd_en, data_rd_en, tx_valid, tx_data, tx_last, tx_bytes,
           tx_core, busy, len_err
  );
endinterface

// File: rtl/prism_sp_tx_frame_arbiter.sv
// prism_sp_tx_frame_arbiter
// Purpose: frame-granular round-robin scheduler sharing one GEM TX stream
//          between NTXCORES TX cores. Pops one meta entry (frame length) per
//          frame, streams exactly ceil(len/B) data words from the chosen
//          core, tags the last beat with its byte count, then idles for
//          GAP_CYCLES cycles.
// Ports:
//   clock  sole clock
//   reset  synchronous, active-high
//   bus    arbiter side (master) of prism_sp_tx_frame_arbiter_if
module prism_sp_tx_frame_arbiter #(
  parameter int unsigned NTXCORES   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 14,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  prism_sp_tx_frame_arbiter_if.master  bus
);

  localparam int unsigned B  = DATA_WIDTH / 8;
  localparam int unsigned BW = $clog2(B) + 1;
  localparam int unsigned CW = (NTXCORES > 1) ? $clog2(NTXCORES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        sel_q, sel_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [CW-1:0]        core_q, core_d;
  logic                 busy_q, busy_d;
  logic                 len_err_q, len_err_d;

  logic                 arb_any;
  logic [CW-1:0]        arb_sel;
  logic [CW-1:0]        arb_idx;
  logic [LEN_WIDTH-1:0] head_len;

  logic [NTXCORES-1:0]   meta_rd_en_c;
  logic [NTXCORES-1:0]   data_rd_en_c;
  logic                  tx_valid_c;
  logic [DATA_WIDTH-1:0] tx_data_c;
  logic                  tx_last_c;
  logic [BW-1:0]         tx_bytes_c;

  // Round-robin search starting just after the last granted core.
  always_comb begin
    arb_any = 1'b0;
    arb_sel = '0;
    arb_idx = '0;
    for (int k = 1; k <= int'(NTXCORES); k++) begin
      arb_idx = CW'((32'(ptr_q) + 32'(k)) % NTXCORES);
      if (!arb_any && !bus.meta_empty[arb_idx]) begin
        arb_any = 1'b1;
        arb_sel = arb_idx;
      end
    end
  end

  assign head_len = bus.meta_len[arb_sel*LEN_WIDTH +: LEN_WIDTH];

  // Next-state and combinational FIFO/stream controls.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    core_d       = core_q;
    busy_d       = busy_q;
    len_err_d    = 1'b0;
    meta_rd_en_c = '0;
    data_rd_en_c = '0;
    tx_valid_c   = 1'b0;
    tx_data_c    = '0;
    tx_last_c    = 1'b0;
    tx_bytes_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          meta_rd_en_c[arb_sel] = 1'b1;
          ptr_d                 = arb_sel;
          // Zero-length entries are consumed and flagged, never streamed.
          if (head_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
            sel_d   = arb_sel;
            rem_d   = head_len;
            core_d  = arb_sel;
            busy_d  = 1'b1;
          end
        end
      end

      ST_STREAM: begin
        tx_valid_c = !bus.data_empty[sel_q];
        tx_data_c  = bus.data_dout[sel_q*DATA_WIDTH +: DATA_WIDTH];
        tx_last_c  = (rem_q <= LEN_WIDTH'(B));
        tx_bytes_c = tx_last_c ? BW'(rem_q) : BW'(B);
        if (tx_valid_c && bus.tx_ready) begin
          data_rd_en_c[sel_q] = 1'b1;
          rem_d               = rem_q - LEN_WIDTH'(B);
          if (tx_last_c) begin
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_CYCLES - 1);
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // No FIFO pops while reset is held; the frame is being dropped.
    if (reset) begin
      meta_rd_en_c = '0;
      data_rd_en_c = '0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= CW'(NTXCORES - 1);
      sel_q     <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      core_q    <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      core_q    <= core_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.meta_rd_en = meta_rd_en_c;
  assign bus.data_rd_en = data_rd_en_c;
  assign bus.tx_valid   = tx_valid_c;
  assign bus.tx_data    = tx_data_c;
  assign bus.tx_last    = tx_last_c;
  assign bus.tx_bytes   = tx_bytes_c;
  assign bus.tx_core    = core_q;
  assign bus.busy       = busy_q;
  assign bus.len_err    = len_err_q;

endmodule

// File: tb/tb_prism_sp_tx_frame_arbiter.sv
// tb_prism_sp_tx_frame_arbiter
// Purpose: scoreboard bench for prism_sp_tx_frame_arbiter with two cores,
//          64-bit words, 14-bit lengths and a one-cycle inter-frame gap.
//          FWFT FIFOs are modelled with queues; loading a frame also queues
//          its expected beats, and a negedge monitor checks every handshake.
module tb_prism_sp_tx_frame_arbiter;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [3:0]  bytes;
    logic        core;
  } beat_t;

  logic clock;
  logic reset;

  prism_sp_tx_frame_arbiter_if #(.NTXCORES(2), .DATA_WIDTH(64), .LEN_WIDTH(14)) bus ();

  prism_sp_tx_frame_arbiter #(
    .NTXCORES(2), .DATA_WIDTH(64), .LEN_WIDTH(14), .GAP_CYCLES(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [13:0] meta_q [2][$];
  logic [63:0] data_q [2][$];
  beat_t       sb [$];
  logic [1:0]  cap_m;
  logic [1:0]  cap_d;
  int          n_total;
  int          n_pass;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pat(input int c, input int f, input int b);
    return {16'hC0DE, 16'(c), 16'(f), 16'(b)};
  endfunction

  task automatic refresh();
    for (int c = 0; c < 2; c++) begin
      bus.meta_empty[c]          = (meta_q[c].size() == 0);
      bus.meta_len[c*14 +: 14]   = (meta_q[c].size() != 0) ? meta_q[c][0] : 14'd0;
      bus.data_empty[c]          = (data_q[c].size() == 0);
      bus.data_dout[c*64 +: 64]  = (data_q[c].size() != 0) ? data_q[c][0] : 64'd0;
    end
  endtask

  // Queue a frame into core c's FIFOs and its beats into the scoreboard.
  task automatic load_frame(input int c, input int len, input int f);
    int nb;
    int rem;
    meta_q[c].push_back(14'(len));
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      rem = len - 8 * b;
      data_q[c].push_back(pat(c, f, b));
      sb.push_back('{data: pat(c, f, b), last: (b == nb - 1),
                     bytes: 4'((rem >= 8) ? 8 : rem), core: 1'(c)});
    end
  endtask

  // Rising edge + 1: apply FIFO pops captured at the previous negedge.
  task automatic edge_();
    @(posedge clock);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (cap_m[c] && meta_q[c].size() != 0) void'(meta_q[c].pop_front());
      if (cap_d[c] && data_q[c].size() != 0) void'(data_q[c].pop_front());
    end
    refresh();
  endtask

  task automatic neg_();
    @(negedge clock);
    cap_m = bus.meta_rd_en;
    cap_d = bus.data_rd_en;
  endtask

  task automatic cyc();
    edge_();
    neg_();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !bus.busy) break;
      cyc();
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meta_rd_en"}, 64'(bus.meta_rd_en), 64'd0);
    check({tag, "_data_rd_en"}, 64'(bus.data_rd_en), 64'd0);
    check({tag, "_tx_valid"},   64'(bus.tx_valid),   64'd0);
    check({tag, "_tx_data"},    bus.tx_data,         64'd0);
    check({tag, "_tx_last"},    64'(bus.tx_last),    64'd0);
    check({tag, "_tx_bytes"},   64'(bus.tx_bytes),   64'd0);
    check({tag, "_tx_core"},    64'(bus.tx_core),    64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_len_err"},    64'(bus.len_err),    64'd0);
  endtask

  // Monitor: consume an expected beat on every handshake.
  initial begin
    beat_t      e;
    logic [1:0] oh;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.busy) check("no_meta_pop_while_busy", 64'(bus.meta_rd_en), 64'd0);
        if (bus.tx_valid && bus.tx_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.core] = 1'b1;
            check("beat_data",  bus.tx_data,          e.data);
            check("beat_last",  64'(bus.tx_last),     64'(e.last));
            check("beat_bytes", 64'(bus.tx_bytes),    64'(e.bytes));
            check("beat_core",  64'(bus.tx_core),     64'(e.core));
            check("beat_pop",   64'(bus.data_rd_en),  64'(oh));
          end
        end else if (bus.busy) begin
          check("no_pop_without_handshake", 64'(bus.data_rd_en), 64'd0);
        end
      end
    end
  end

  initial begin
    int cnt;
    int seq [$];
    n_total = 0;
    n_pass  = 0;
    cap_m   = '0;
    cap_d   = '0;
    reset   = 1'b1;
    bus.tx_ready = 1'b0;
    refresh();

    // Reset state.
    cyc();
    cyc();
    edge_();
    reset = 1'b0;
    neg_();
    check_all_zero("rst");

    // Single 64-byte frame on core 0: 8 beats, one gap cycle, then idle.
    edge_();
    bus.tx_ready = 1'b1;
    load_frame(0, 64, 1);
    refresh();
    neg_();
    check("t1_meta_pop", 64'(bus.meta_rd_en), 64'b01);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("t1_beat%0d_busy_valid_last", k),
            64'({bus.busy, bus.tx_valid, bus.tx_last}), 64'({1'b1, 1'b1, (k == 8)}));
    end
    cyc();
    check("t1_gap", 64'({bus.busy, bus.tx_valid, bus.tx_last}), 64'b100);
    cyc();
    check("t1_idle", 64'({bus.busy, bus.tx_valid, bus.tx_last}), 64'b000);

    // 13-byte frame on core 1: beats of 8 and 5 bytes, two data pops.
    edge_();
    load_frame(1, 13, 2);
    refresh();
    neg_();
    check("t2_meta_pop", 64'(bus.meta_rd_en), 64'b10);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.data_rd_en[1]) cnt++;
    end
    check("t2_pop_count", 64'(cnt), 64'd2);

    // Both cores always pending: service alternates 0,1,0,1,0,1.
    edge_();
    for (int i = 0; i < 3; i++) begin
      load_frame(0, 24, 10 + 2 * i);
      load_frame(1, 10, 11 + 2 * i);
    end
    refresh();
    neg_();
    if (bus.meta_rd_en != 0) seq.push_back(bus.meta_rd_en[1] ? 1 : 0);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !bus.busy) break;
      cyc();
      if (bus.meta_rd_en != 0) seq.push_back(bus.meta_rd_en[1] ? 1 : 0);
    end
    check("t3_drain", 64'(sb.size()), 64'd0);
    check("t3_frames", 64'(seq.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < seq.size()) check($sformatf("t3_core_seq%0d", i), 64'(seq[i]), 64'(i % 2));

    // Back-pressure 1,0,0,1 mid-frame: data held, no pops while stalled.
    edge_();
    load_frame(0, 32, 20);
    refresh();
    neg_();
    check("t4_meta_pop", 64'(bus.meta_rd_en), 64'b01);
    cyc();
    edge_();
    bus.tx_ready = 1'b0;
    neg_();
    check("t4_stall1_valid", 64'(bus.tx_valid), 64'd1);
    check("t4_stall1_data", bus.tx_data, pat(0, 20, 1));
    check("t4_stall1_pop", 64'(bus.data_rd_en), 64'd0);
    cyc();
    check("t4_stall2_data", bus.tx_data, pat(0, 20, 1));
    check("t4_stall2_pop", 64'(bus.data_rd_en), 64'd0);
    edge_();
    bus.tx_ready = 1'b1;
    neg_();
    check("t4_resume_pop", 64'(bus.data_rd_en), 64'b01);
    drain("t4_drain");

    // Zero-length entry on core 1 is dropped; core 0 is served next.
    edge_();
    load_frame(1, 0, 30);
    load_frame(0, 8, 31);
    refresh();
    neg_();
    check("t5_zero_pop", 64'(bus.meta_rd_en), 64'b10);
    check("t5_zero_novalid", 64'(bus.tx_valid), 64'd0);
    cyc();
    check("t5_len_err", 64'(bus.len_err), 64'd1);
    check("t5_next_pop", 64'(bus.meta_rd_en), 64'b01);
    check("t5_err_novalid", 64'(bus.tx_valid), 64'd0);
    cyc();
    check("t5_len_err_clear", 64'(bus.len_err), 64'd0);
    drain("t5_drain");

    // Reset during beat 3 of an 8-beat frame.
    edge_();
    load_frame(0, 64, 40);
    refresh();
    neg_();
    cyc();
    cyc();
    edge_();
    reset = 1'b1;
    neg_();
    edge_();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      meta_q[c].delete();
      data_q[c].delete();
    end
    sb.delete();
    refresh();
    neg_();
    check_all_zero("midrst");

    // Pointer back at NTXCORES-1: core 0 wins over core 1.
    edge_();
    load_frame(0, 8, 42);
    load_frame(1, 8, 41);
    refresh();
    neg_();
    check("t6_ptr_first", 64'(bus.meta_rd_en), 64'b01);
    drain("t6_drain");

    cyc();
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prism_sp_tx_frame_arbiter.md
Name: prism_sp_tx_frame_arbiter

Overview:
- Frame-granular round-robin scheduler that shares the single GEM TX stream between NTXCORES TX cores.
- Sits between the per-core TX meta/data FIFO read sides (first-word-fall-through) and the gem_tx datapath.
- Picks one core per frame and pops its meta entry (frame length). It then streams exactly that frame's data words, marks the last beat with a byte count, and enforces a programmable inter-frame gap.

Parameters:
- NTXCORES, 2, number of requesting TX cores (>=1).
- DATA_WIDTH, 64, data FIFO / output word width in bits (multiple of 8, power of two).
- LEN_WIDTH, 14, frame length field width in bytes.
- GAP_CYCLES, 1, idle cycles inserted after each frame's last beat (0 allowed).

Ports:
- clock, in, 1, sole clock.
- reset, in, 1, synchronous, active-high reset.
- meta_empty, in, NTXCORES, per-core meta FIFO empty.
- meta_len, in, NTXCORES*LEN_WIDTH, per-core head-of-FIFO frame length in bytes (core i at [i*LEN_WIDTH +: LEN_WIDTH]).
- meta_rd_en, out, NTXCORES, per-core meta pop, one-hot, one-cycle pulse.
- data_empty, in, NTXCORES, per-core data FIFO empty.
- data_dout, in, NTXCORES*DATA_WIDTH, per-core head-of-FIFO data word.
- data_rd_en, out, NTXCORES, per-core data pop, at most one-hot.
- tx_valid, out, 1, output beat valid.
- tx_ready, in, 1, downstream accepts beat.
- tx_data, out, DATA_WIDTH, output beat data.
- tx_last, out, 1, beat is the final beat of the frame.
- tx_bytes, out, $clog2(DATA_WIDTH/8)+1, valid bytes in beat (B=DATA_WIDTH/8 except on last).
- tx_core, out, max(1,$clog2(NTXCORES)), index of the core currently owning the stream.
- busy, out, 1, high while in STREAM or GAP.
- len_err, out, 1, one-cycle pulse when a zero-length meta entry is discarded.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer ptr = NTXCORES-1, so core 0 has first priority. State = IDLE.
- Reset mid-frame drops the frame immediately. FIFOs are not flushed here; flushing is the owning core's responsibility.
- States:
  - IDLE → STREAM when any !meta_empty.
  - STREAM → GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0) on last-beat handshake.
  - GAP counts GAP_CYCLES cycles, then → IDLE.
- Arbitration (IDLE, cycle t):
  - sel = first i in order ptr+1 … ptr+NTXCORES (mod N) with !meta_empty[i].
  - Combinationally assert meta_rd_en[sel] in cycle t.
  - Latch len = meta_len[sel], sel and ptr <= sel.
  - Enter STREAM at t+1.
- Zero-length entry: len==0 is popped in IDLE and not streamed. Pulse len_err at t+1, stay IDLE, and advance ptr.
- Word count: words = ceil(len/B). A remaining-bytes counter rem is loaded with len.
- STREAM output:
  - tx_valid = !data_empty[sel]; tx_data = data_dout[sel] (combinational mux).
  - data_rd_en[sel] = tx_valid & tx_ready.
  - On each handshake, rem <= rem - B.
  - tx_last = (rem <= B). tx_bytes = tx_last ? rem : B.
- Handshake: tx_valid, once asserted, does not deassert before a handshake unless data_empty rises. That cannot happen with FWFT FIFOs because the arbiter is the only reader. tx_data is stable while tx_valid & !tx_ready.
- tx_core and busy are registered and updated on entry to STREAM. tx_core holds its value through GAP and IDLE.
- No preemption: a frame is never interrupted. Other cores' meta_rd_en and data_rd_en stay 0 while streaming.
- Back-to-back: with GAP_CYCLES=0, the last handshake at cycle n → IDLE at n+1 → next meta_rd_en at n+1 → first beat at n+2.
- Data underrun (data_empty[sel] mid-frame) only stalls tx_valid. There is no timeout.

Test Plan:
- Single core 0, len=64, B=8, GAP=1 → meta_rd_en[0] at t, 8 beats t+1..t+8 with tx_ready=1; tx_last on the 8th with tx_bytes=8; busy high t+1..t+9; idle at t+10.
- len=13, B=8 → 2 beats, tx_bytes=8 then 5, tx_last only on the 2nd; data_rd_en pulses exactly twice.
- Cores 0 and 1 both always pending, 3 frames each → tx_core sequence 0,1,0,1,0,1; meta_rd_en never asserts during STREAM.
- tx_ready toggled 1,0,0,1 mid-frame → tx_data held constant while stalled; no data_rd_en when tx_ready=0; beat count unchanged.
- Core 1 meta len=0 → meta_rd_en[1] pulse, len_err pulse next cycle, no tx_valid; next pending core served afterwards.
- reset asserted during beat 3 of an 8-beat frame → next cycle all outputs 0, state IDLE, ptr=NTXCORES-1.
